step_counter_scheduler: RTL and testbench

Arbitrates one 4-bit step counter between two requesters, A and B. An up step adds 3 and a down step subtracts 5, both mod 16.
Each requester submits a burst of N steps in one direction over a valid/ready handshake. Bursts run to completion, one at a time, with round-robin fairness.
The block drives the counter's hold/select controls and keeps a shadow copy of the count for status readback.

---
 rtl/step_counter_scheduler.sv | 125 ++++++++++++
 tb/tb_step_counter_scheduler.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_counter_scheduler.sv
// Step counter scheduler: arbitrates one 4-bit +STEP_UP / -STEP_DN counter
// between two burst requesters A and B. Bursts run to completion with
// round-robin fairness, and a shadow copy of the count is kept for readback.
module step_counter_scheduler #(
   parameter int LEN_W   = 4,
   parameter int STEP_UP = 3,
   parameter int STEP_DN = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic             a_dir,
   input  logic [LEN_W-1:0] a_len,
   input  logic             b_valid,
   output logic             b_ready,
   input  logic             b_dir,
   input  logic [LEN_W-1:0] b_len,
   output logic             ctr_hold,
   output logic             ctr_up,
   output logic [3:0]       shadow_q,
   output logic             busy,
   output logic             owner,
   output logic             done,
   output logic             done_owner
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // A down step is applied as an addition of its mod-16 complement.
   localparam logic [3:0]       up_inc  = 4'(STEP_UP % 16);
   localparam logic [3:0]       dn_inc  = 4'((16 - (STEP_DN % 16)) % 16);
   localparam logic [LEN_W-1:0] len_one = LEN_W'(1);

   state_t           state;
   state_t           state_nx;
   logic             rr_ptr;     // 0: A wins a tie, 1: B wins a tie
   logic [LEN_W-1:0] remaining;  // steps still to issue in the current burst
   logic             sel_dir;
   logic [LEN_W-1:0] sel_len;
   logic             accept;

   // Grant arbitration and next-state decode; readies only exist in IDLE.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      a_ready  = 1'b0;
      b_ready  = 1'b0;
      sel_dir  = a_dir;
      sel_len  = a_len;
      state_nx = state;
      case (state)
         IDLE: begin
            if (a_valid && (!b_valid || !rr_ptr)) begin
               a_ready = 1'b1;
            end else if (b_valid) begin
               b_ready = 1'b1;
               sel_dir = b_dir;
               sel_len = b_len;
            end
            if (a_ready || b_ready) begin
               state_nx = (sel_len == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (remaining == len_one) begin
               state_nx = DONE;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign accept     = a_ready | b_ready;
   assign ctr_hold   = (state != RUN);
   assign busy       = (state != IDLE);
   assign done       = (state == DONE);
   assign done_owner = done & owner;

   // FSM state register with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Burst capture on handshake, then shadow count and step bookkeeping.
   always_ff @(posedge clk) begin
      // NOTE: every control register is reset here; reset discards an
      // in-flight burst outright, so no done pulse can follow it.
      if (rst) begin
         ctr_up    <= 1'b0;
         shadow_q  <= 4'd0;
         owner     <= 1'b0;
         rr_ptr    <= 1'b0;
         remaining <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  owner     <= b_ready;
                  ctr_up    <= sel_dir;
                  remaining <= sel_len;
                  rr_ptr    <= a_ready;  // next tie goes to the side not served
               end
            end
            RUN: begin
               shadow_q  <= shadow_q + (ctr_up ? up_inc : dn_inc);
               remaining <= remaining - len_one;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_step_counter_scheduler.sv
// Self-checking bench for step_counter_scheduler: directed scenarios with
// literal expectations, then randomized traffic against a transaction model.
module tb_step_counter_scheduler;

   localparam int STEP_UP = 3;
   localparam int STEP_DN = 5;

   logic       clk = 1'b0;
   logic       rst;
   logic       a_valid, a_dir, b_valid, b_dir;
   logic [3:0] a_len, b_len;
   logic       a_ready, b_ready, ctr_hold, ctr_up, busy, owner, done, done_owner;
   logic [3:0] shadow_q;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   step_counter_scheduler #(.LEN_W(4), .STEP_UP(STEP_UP), .STEP_DN(STEP_DN)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_dir(a_dir), .a_len(a_len),
      .b_valid(b_valid), .b_ready(b_ready), .b_dir(b_dir), .b_len(b_len),
      .ctr_hold(ctr_hold), .ctr_up(ctr_up), .shadow_q(shadow_q),
      .busy(busy), .owner(owner), .done(done), .done_owner(done_owner)
   );

   // ---------------- transaction-level reference model ----------------
   int m_shadow;   // counter value as a plain integer 0..15
   int m_steps;    // steps of the current burst still to be applied
   bit m_pending;  // a burst was accepted and its completion not yet reported
   bit m_dir, m_owner, m_rr;

   function automatic void model_reset();
      m_shadow = 0; m_steps = 0; m_pending = 0;
      m_dir = 0; m_owner = 0; m_rr = 0;
   endfunction

   function automatic bit m_idle();
      return (m_steps == 0) && !m_pending;
   endfunction

   function automatic bit m_grant_a();
      return m_idle() && a_valid && (!b_valid || !m_rr);
   endfunction

   function automatic bit m_grant_b();
      return m_idle() && b_valid && !m_grant_a();
   endfunction

   // Advance the model across one rising edge using the current inputs.
   function automatic void model_advance();
      if (rst) begin
         model_reset();
      end else if (m_steps > 0) begin
         m_shadow = (m_shadow + (m_dir ? STEP_UP : 16 - STEP_DN)) % 16;
         m_steps--;
      end else if (m_pending) begin
         m_pending = 0;
      end else if (m_grant_a()) begin
         m_owner = 0; m_dir = a_dir; m_steps = a_len; m_pending = 1; m_rr = 1;
      end else if (m_grant_b()) begin
         m_owner = 1; m_dir = b_dir; m_steps = b_len; m_pending = 1; m_rr = 0;
      end
   endfunction

   // ---------------- stimulus utilities ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
      cyc();
      rst = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1; a_valid = 0; b_valid = 0; a_dir = 0; b_dir = 0; a_len = 0; b_len = 0;
      cyc();
      @(negedge clk);
      checks++;
      if ({a_ready, b_ready, ctr_hold, ctr_up, shadow_q, busy, owner, done, done_owner}
          !== {1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state got %b exp %b",
                  {a_ready, b_ready, ctr_hold, ctr_up, shadow_q, busy, owner, done, done_owner},
                  12'b001000000000);
      end
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_up_burst();
      a_valid = 1; a_dir = 1; a_len = 3;
      @(negedge clk);
      checks++;
      if ({a_ready, b_ready} !== 2'b10) begin
         errors++; $display("FAIL up_accept got %b exp 10", {a_ready, b_ready});
      end
      cyc();
      a_valid = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({ctr_hold, ctr_up, busy, done, a_ready, shadow_q} !== {5'b01100, 4'(3 * i)}) begin
            errors++;
            $display("FAIL up_run%0d got %b exp %b", i,
                     {ctr_hold, ctr_up, busy, done, a_ready, shadow_q}, {5'b01100, 4'(3 * i)});
         end
         cyc();
      end
      @(negedge clk);
      checks++;
      if ({ctr_hold, busy, done, done_owner, shadow_q} !== {4'b1110, 4'd9}) begin
         errors++;
         $display("FAIL up_done got %b exp %b", {ctr_hold, busy, done, done_owner, shadow_q}, 8'b11101001);
      end
      cyc();
      @(negedge clk);
      checks++;
      if ({busy, done, ctr_hold} !== 3'b001) begin
         errors++; $display("FAIL up_idle got %b exp 001", {busy, done, ctr_hold});
      end
      cyc();
   endtask

   task automatic test_down_burst();
      logic [3:0] exp_s;
      b_valid = 1; b_dir = 0; b_len = 2;
      @(negedge clk);
      checks++;
      if ({a_ready, b_ready} !== 2'b01) begin
         errors++; $display("FAIL dn_accept got %b exp 01", {a_ready, b_ready});
      end
      cyc();
      b_valid = 0;
      for (int i = 0; i < 2; i++) begin
         exp_s = (i == 0) ? 4'd9 : 4'd4;
         @(negedge clk);
         checks++;
         if ({ctr_hold, ctr_up, busy, shadow_q} !== {3'b001, exp_s}) begin
            errors++;
            $display("FAIL dn_run%0d got %b exp %b", i, {ctr_hold, ctr_up, busy, shadow_q}, {3'b001, exp_s});
         end
         cyc();
      end
      @(negedge clk);
      checks++;
      if ({done, done_owner, ctr_hold, shadow_q} !== {3'b111, 4'd15}) begin
         errors++;
         $display("FAIL dn_done got %b exp 1111111", {done, done_owner, ctr_hold, shadow_q});
      end
      cyc();
   endtask

   task automatic test_fairness();
      bit exp_b;
      do_reset();
      a_valid = 1; a_dir = 1; a_len = 1;
      b_valid = 1; b_dir = 1; b_len = 1;
      for (int k = 0; k < 4; k++) begin
         exp_b = (k % 2 == 1);
         @(negedge clk);
         checks++;
         if ({a_ready, b_ready} !== {!exp_b, exp_b}) begin
            errors++; $display("FAIL rr_grant%0d got %b exp %b", k, {a_ready, b_ready}, {!exp_b, exp_b});
         end
         cyc();
         @(negedge clk);
         checks++;
         if ({a_ready, b_ready, ctr_hold} !== 3'b000) begin
            errors++; $display("FAIL rr_run%0d got %b exp 000", k, {a_ready, b_ready, ctr_hold});
         end
         cyc();
         @(negedge clk);
         checks++;
         if ({a_ready, b_ready, done, done_owner, shadow_q} !== {3'b001, exp_b, 4'(3 * (k + 1))}) begin
            errors++;
            $display("FAIL rr_done%0d got %b exp %b", k, {a_ready, b_ready, done, done_owner, shadow_q},
                     {3'b001, exp_b, 4'(3 * (k + 1))});
         end
         cyc();
      end
      a_valid = 0; b_valid = 0;
   endtask

   task automatic test_zero_len();
      a_valid = 1; a_dir = 1; a_len = 0;
      @(negedge clk);
      checks++;
      if ({a_ready, b_ready, ctr_hold} !== 3'b101) begin
         errors++; $display("FAIL z_accept got %b exp 101", {a_ready, b_ready, ctr_hold});
      end
      cyc();
      @(negedge clk);
      checks++;
      if ({done, done_owner, ctr_hold, a_ready, shadow_q} !== {4'b1010, 4'd12}) begin
         errors++;
         $display("FAIL z_done got %b exp 10101100", {done, done_owner, ctr_hold, a_ready, shadow_q});
      end
      cyc();
      @(negedge clk);
      checks++;
      if ({a_ready, busy, ctr_hold} !== 3'b101) begin
         errors++; $display("FAIL z_reaccept got %b exp 101", {a_ready, busy, ctr_hold});
      end
      cyc();
      a_valid = 0;
      @(negedge clk);
      checks++;
      if ({done, ctr_hold, shadow_q} !== {2'b11, 4'd12}) begin
         errors++; $display("FAIL z_done2 got %b exp 111100", {done, ctr_hold, shadow_q});
      end
      cyc();
   endtask

   task automatic test_wrap();
      do_reset();
      a_valid = 1; a_dir = 1; a_len = 6;
      @(negedge clk);
      checks++;
      if (a_ready !== 1'b1) begin
         errors++; $display("FAIL wrap_accept got %b exp 1", a_ready);
      end
      cyc();
      a_valid = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if ({ctr_hold, ctr_up, shadow_q} !== {2'b01, 4'((3 * i) % 16)}) begin
            errors++;
            $display("FAIL wrap_run%0d got %b exp %b", i, {ctr_hold, ctr_up, shadow_q}, {2'b01, 4'((3 * i) % 16)});
         end
         cyc();
      end
      @(negedge clk);
      checks++;
      if ({done, shadow_q} !== {1'b1, 4'd2}) begin
         errors++; $display("FAIL wrap_up_end got %b exp 10010", {done, shadow_q});
      end
      cyc();
      a_valid = 1; a_dir = 0; a_len = 1;
      @(negedge clk);
      cyc();
      a_valid = 0;
      @(negedge clk);
      checks++;
      if ({ctr_hold, ctr_up, shadow_q} !== {2'b00, 4'd2}) begin
         errors++; $display("FAIL wrap_dn_run got %b exp 000010", {ctr_hold, ctr_up, shadow_q});
      end
      cyc();
      @(negedge clk);
      checks++;
      if ({done, shadow_q} !== {1'b1, 4'd13}) begin
         errors++; $display("FAIL wrap_dn_end got %b exp 11101", {done, shadow_q});
      end
      cyc();
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      a_valid = 1; a_dir = 1; a_len = 5;
      @(negedge clk);
      cyc();
      a_valid = 0;
      @(negedge clk);
      checks++;
      if ({ctr_hold, shadow_q} !== {1'b0, 4'd0}) begin
         errors++; $display("FAIL mid_run1 got %b exp 00000", {ctr_hold, shadow_q});
      end
      cyc();
      rst = 1;
      @(negedge clk);
      checks++;
      if ({ctr_hold, shadow_q} !== {1'b0, 4'd3}) begin
         errors++; $display("FAIL mid_run2 got %b exp 00011", {ctr_hold, shadow_q});
      end
      cyc();
      rst = 0;
      a_valid = 1; a_dir = 1; a_len = 1;
      b_valid = 1; b_dir = 1; b_len = 1;
      @(negedge clk);
      checks++;
      if ({ctr_hold, busy, done, shadow_q, a_ready, b_ready} !== {3'b100, 4'd0, 2'b10}) begin
         errors++;
         $display("FAIL mid_after_rst got %b exp 100000010", {ctr_hold, busy, done, shadow_q, a_ready, b_ready});
      end
      cyc();
      a_valid = 0; b_valid = 0;
      @(negedge clk);
      cyc();
      @(negedge clk);
      checks++;
      if ({done, done_owner, shadow_q} !== {2'b10, 4'd3}) begin
         errors++; $display("FAIL mid_new_done got %b exp 100011", {done, done_owner, shadow_q});
      end
      cyc();
   endtask

   task automatic test_random();
      bit took_a, took_b, e_a, e_b, e_done;
      logic [11:0] got, exp;
      do_reset();
      model_reset();
      took_a = 0; took_b = 0;
      for (int c = 0; c < 1500; c++) begin
         if (!a_valid || took_a) begin
            a_valid = 1'($urandom_range(0, 1));
            a_dir = 1'($urandom); a_len = 4'($urandom_range(0, 15));
         end else if ($urandom_range(0, 3) == 0) begin
            a_dir = 1'($urandom); a_len = 4'($urandom_range(0, 15));
         end
         if (!b_valid || took_b) begin
            b_valid = 1'($urandom_range(0, 1));
            b_dir = 1'($urandom); b_len = 4'($urandom_range(0, 15));
         end else if ($urandom_range(0, 3) == 0) begin
            b_dir = 1'($urandom); b_len = 4'($urandom_range(0, 15));
         end
         rst = ($urandom_range(0, 99) == 0);
         @(negedge clk);
         e_a    = m_grant_a();
         e_b    = m_grant_b();
         e_done = m_pending && (m_steps == 0);
         exp = {e_a, e_b, m_steps == 0, m_dir, !m_idle(), e_done, m_owner, e_done & m_owner, 4'(m_shadow)};
         got = {a_ready, b_ready, ctr_hold, ctr_up, busy, done, owner, done_owner, shadow_q};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL rand_cycle%0d got %b exp %b (rdyA rdyB hold up busy done own down shadow)", c, got, exp);
         end
         took_a = e_a && !rst;
         took_b = e_b && !rst;
         model_advance();
         cyc();
      end
      rst = 0; a_valid = 0; b_valid = 0;
   endtask

   initial begin
      test_reset();
      test_up_burst();
      test_down_burst();
      test_fairness();
      test_zero_len();
      test_wrap();
      test_reset_mid_burst();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
